// File: rtl/spi_slave_rx.sv
// SPI slave receiver: synchronizes sclk/cs/mosi into clk, assembles MSB-first words
// on sclk falling edges and queues them in a small FIFO drained with valid/ready.
module spi_slave_rx #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sclk,
    input  logic                        cs,
    input  logic                        mosi,
    output logic [DATA_W-1:0]           rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] rx_level,
    output logic                        overflow,
    output logic                        frame_err,
    output logic                        busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state_q, state_d;

    // [0],[1] are the synchronizer stages; [2] is the edge-detect history flop.
    logic [2:0] sclk_s;
    logic [2:0] cs_s;
    logic [1:0] mosi_s;
    logic       sync_fill;
    logic       cs_armed;
    logic       sclk_fall_q;
    logic       cs_fall_q;
    logic       cs_rise_q;

    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_next;

    logic clr;
    logic shift_en;
    logic push;
    logic frame_err_d;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  count_q;
    logic              full;
    logic              pop;
    logic              wr_en;

    // cs_armed blocks a frame that was already running when reset released:
    // cs must be seen high (after the synchronizer has refilled) before a fall counts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_s      <= '0;
            cs_s        <= '1;
            mosi_s      <= '0;
            sync_fill   <= 1'b0;
            cs_armed    <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
        end else begin
            sclk_s      <= {sclk_s[1:0], sclk};
            cs_s        <= {cs_s[1:0], cs};
            mosi_s      <= {mosi_s[0], mosi};
            sync_fill   <= 1'b1;
            cs_armed    <= cs_armed | (sync_fill & cs_s[0]);
            sclk_fall_q <= sclk_s[2] & ~sclk_s[1];
            cs_fall_q   <= cs_armed & cs_s[2] & ~cs_s[1];
            cs_rise_q   <= ~cs_s[2] & cs_s[1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign shift_next = {shift_q[DATA_W-2:0], mosi_s[1]};

    // A cs rise takes priority over an sclk fall seen in the same cycle.
    always_comb begin
        state_d     = state_q;
        clr         = 1'b0;
        shift_en    = 1'b0;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall_q) begin
                    state_d = ACTIVE;
                    clr     = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise_q) begin
                    state_d     = IDLE;
                    clr         = 1'b1;
                    frame_err_d = (bit_cnt != '0);
                end else if (sclk_fall_q) begin
                    shift_en = 1'b1;
                    push     = (bit_cnt == LAST_BIT);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt   <= '0;
            shift_q   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= frame_err_d;
            if (clr) begin
                bit_cnt <= '0;
                shift_q <= '0;
            end else if (shift_en) begin
                shift_q <= shift_next;
                bit_cnt <= push ? '0 : bit_cnt + CNT_ONE;
            end
        end
    end

    // Handshake: the head word transfers on any clk edge where rx_valid and rx_ready
    // are both high; rx_data is stable while rx_valid is high and rx_ready is low.
    assign rx_valid = (count_q != '0);
    assign full     = (count_q == FULL_LVL);
    assign pop      = rx_ready & rx_valid;
    assign wr_en    = push & (~full | pop);
    assign rx_data  = rx_valid ? mem[rd_ptr] : '0;
    assign rx_level = count_q;
    assign busy     = (state_q == ACTIVE);

    // When full, a simultaneous pop frees the head slot that wr_ptr points at.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= shift_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push & full & ~pop;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + LVL_ONE;
                2'b01:   count_q <= count_q - LVL_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: drives an SPI master on clk negedges and checks received
// words against a queue model of the FIFO with drop-on-full behaviour.
module tb_spi_slave_rx;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int HALF   = 6;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic              clk      = 1'b0;
    logic              rst      = 1'b0;
    logic              sclk     = 1'b0;
    logic              cs       = 1'b1;
    logic              mosi     = 1'b0;
    logic              rx_ready = 1'b0;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic [LVL_W-1:0]  rx_level;
    logic              overflow;
    logic              frame_err;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W-1:0] exp_q[$];
    int exp_drop = 0;

    spi_slave_rx #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .cs       (cs),
        .mosi     (mosi),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_level (rx_level),
        .overflow (overflow),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts high cycles and rising events so pulse width can be checked.
    int   ovf_cycles = 0;
    int   ovf_rises  = 0;
    int   ferr_cycles = 0;
    int   ferr_rises  = 0;
    logic ovf_prev  = 1'b0;
    logic ferr_prev = 1'b0;
    always @(negedge clk) begin
        if (overflow === 1'b1) ovf_cycles++;
        if (overflow === 1'b1 && ovf_prev !== 1'b1) ovf_rises++;
        if (frame_err === 1'b1) ferr_cycles++;
        if (frame_err === 1'b1 && ferr_prev !== 1'b1) ferr_rises++;
        ovf_prev  = overflow;
        ferr_prev = frame_err;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- drivers ----------------
    task automatic spi_bit(input logic b);
        sclk = 1'b1;
        mosi = b;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [DATA_W-1:0] w, input int n);
        for (int i = 0; i < n; i++) spi_bit(w[DATA_W-1-i]);
    endtask

    task automatic cs_start();
        cs = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_end();
        cs = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic pop_word(output logic [DATA_W-1:0] d);
        d = rx_data;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic model_push(input logic [DATA_W-1:0] w);
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else exp_drop++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp 0", rx_valid); end
        n_cmp++; if (int'(rx_level) !== 0) begin n_err++; $display("FAIL reset_level: got %0d exp 0", rx_level); end
        n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h exp 00", rx_data); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b exp 0", overflow); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b exp 0", frame_err); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", busy); end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy: got %b exp 0", busy); end
    endtask

    task automatic test_single_word();
        int f_c;
        logic [DATA_W-1:0] d;
        f_c = ferr_cycles;
        cs_start();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b exp 1", busy); end
        spi_bits(8'h92, 8);
        cs_end();
        n_cmp++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b exp 1", rx_valid); end
        n_cmp++; if (rx_data !== 8'h92) begin n_err++; $display("FAIL single_data: got %h exp 92", rx_data); end
        n_cmp++; if (int'(rx_level) !== 1) begin n_err++; $display("FAIL single_level: got %0d exp 1", rx_level); end
        n_cmp++; if (ferr_cycles - f_c !== 0) begin n_err++; $display("FAIL single_ferr: got %0d pulses exp 0", ferr_cycles - f_c); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got busy %b exp 0", busy); end
        pop_word(d);
        n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL single_drained: got valid %b exp 0", rx_valid); end
    endtask

    task automatic test_latency();
        logic [DATA_W-1:0] w, d;
        int k;
        w = DATA_W'($urandom);
        cs_start();
        spi_bits(w, 7);
        sclk = 1'b1;
        mosi = w[0];
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
        k = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (rx_valid === 1'b1 && k == 0) k = i;
        end
        n_cmp++; if (k !== 4) begin n_err++; $display("FAIL latency: rx_valid after %0d edges exp 4", k); end
        @(negedge clk);
        repeat (HALF) @(negedge clk);
        cs_end();
        pop_word(d);
        n_cmp++; if (d !== w) begin n_err++; $display("FAIL latency_data: got %h exp %h", d, w); end
    endtask

    task automatic test_multi_word();
        logic [DATA_W-1:0] words [4];
        logic [DATA_W-1:0] d, e;
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h00;
        exp_q.delete();
        exp_drop = 0;
        cs_start();
        for (int i = 0; i < 4; i++) begin
            model_push(words[i]);
            spi_bits(words[i], 8);
        end
        cs_end();
        n_cmp++; if (int'(rx_level) !== 4) begin n_err++; $display("FAIL multi_level: got %0d exp 4", rx_level); end
        for (int i = 0; i < 4; i++) begin
            pop_word(d);
            e = exp_q.pop_front();
            n_cmp++; if (d !== e) begin n_err++; $display("FAIL multi_word%0d: got %h exp %h", i, d, e); end
        end
        n_cmp++; if (int'(rx_level) !== 0) begin n_err++; $display("FAIL multi_empty: got %0d exp 0", rx_level); end
    endtask

    task automatic test_overflow();
        int o_c, o_r;
        logic [DATA_W-1:0] d, e;
        o_c = ovf_cycles;
        o_r = ovf_rises;
        exp_q.delete();
        exp_drop = 0;
        cs_start();
        for (int i = 0; i < 5; i++) begin
            e = DATA_W'($urandom);
            model_push(e);
            spi_bits(e, 8);
        end
        cs_end();
        n_cmp++; if (ovf_rises - o_r !== exp_drop) begin n_err++; $display("FAIL ovf_pulses: got %0d exp %0d", ovf_rises - o_r, exp_drop); end
        n_cmp++; if (ovf_cycles - o_c !== exp_drop) begin n_err++; $display("FAIL ovf_width: got %0d cycles exp %0d", ovf_cycles - o_c, exp_drop); end
        n_cmp++; if (int'(rx_level) !== DEPTH) begin n_err++; $display("FAIL ovf_level: got %0d exp %0d", rx_level, DEPTH); end
        while (exp_q.size() > 0) begin
            pop_word(d);
            e = exp_q.pop_front();
            n_cmp++; if (d !== e) begin n_err++; $display("FAIL ovf_word: got %h exp %h", d, e); end
        end
    endtask

    task automatic test_frame_err();
        int f_c, f_r;
        logic [DATA_W-1:0] d;
        f_c = ferr_cycles;
        f_r = ferr_rises;
        cs_start();
        spi_bits(DATA_W'($urandom), 5);
        cs_end();
        n_cmp++; if (ferr_rises - f_r !== 1) begin n_err++; $display("FAIL ferr_pulses: got %0d exp 1", ferr_rises - f_r); end
        n_cmp++; if (ferr_cycles - f_c !== 1) begin n_err++; $display("FAIL ferr_width: got %0d cycles exp 1", ferr_cycles - f_c); end
        n_cmp++; if (int'(rx_level) !== 0) begin n_err++; $display("FAIL ferr_level: got %0d exp 0", rx_level); end
        cs_start();
        spi_bits(8'h81, 8);
        cs_end();
        n_cmp++; if (ferr_rises - f_r !== 1) begin n_err++; $display("FAIL ferr_clean: got %0d pulses exp 1", ferr_rises - f_r); end
        n_cmp++; if (int'(rx_level) !== 1) begin n_err++; $display("FAIL ferr_next_level: got %0d exp 1", rx_level); end
        pop_word(d);
        n_cmp++; if (d !== 8'h81) begin n_err++; $display("FAIL ferr_next_word: got %h exp 81", d); end
    endtask

    task automatic test_full_pop();
        int o_c;
        logic [DATA_W-1:0] w5, head, d, e;
        o_c = ovf_cycles;
        exp_q.delete();
        exp_drop = 0;
        cs_start();
        for (int i = 0; i < 4; i++) begin
            e = DATA_W'($urandom);
            model_push(e);
            spi_bits(e, 8);
        end
        w5 = DATA_W'($urandom);
        spi_bits(w5, 7);
        sclk = 1'b1;
        mosi = w5[0];
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
        // the last bit is written on the 4th edge; hold rx_ready across exactly that edge
        repeat (3) @(negedge clk);
        head = rx_data;
        e = exp_q.pop_front();
        n_cmp++; if (head !== e) begin n_err++; $display("FAIL fullpop_head: got %h exp %h", head, e); end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        model_push(w5);
        repeat (HALF) @(negedge clk);
        cs_end();
        n_cmp++; if (ovf_cycles - o_c !== 0) begin n_err++; $display("FAIL fullpop_ovf: got %0d pulses exp 0", ovf_cycles - o_c); end
        n_cmp++; if (int'(rx_level) !== DEPTH) begin n_err++; $display("FAIL fullpop_level: got %0d exp %0d", rx_level, DEPTH); end
        while (exp_q.size() > 0) begin
            pop_word(d);
            e = exp_q.pop_front();
            n_cmp++; if (d !== e) begin n_err++; $display("FAIL fullpop_word: got %h exp %h", d, e); end
        end
    endtask

    task automatic test_idle_sclk();
        int f_c;
        f_c = ferr_cycles;
        for (int i = 0; i < 8; i++) spi_bit(1'($urandom));
        n_cmp++; if (int'(rx_level) !== 0) begin n_err++; $display("FAIL idle_level: got %0d exp 0", rx_level); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b exp 0", busy); end
        n_cmp++; if (ferr_cycles - f_c !== 0) begin n_err++; $display("FAIL idle_ferr: got %0d exp 0", ferr_cycles - f_c); end
    endtask

    task automatic test_reset_mid_word();
        int f_c;
        logic [DATA_W-1:0] d;
        cs_start();
        spi_bits(DATA_W'($urandom), 8);
        spi_bits(DATA_W'($urandom), 8);
        cs_end();
        n_cmp++; if (int'(rx_level) !== 2) begin n_err++; $display("FAIL rmid_prefill: got %0d exp 2", rx_level); end
        cs_start();
        spi_bits(DATA_W'($urandom), 3);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b exp 0", rx_valid); end
        n_cmp++; if (int'(rx_level) !== 0) begin n_err++; $display("FAIL rmid_level: got %0d exp 0", rx_level); end
        n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL rmid_data: got %h exp 00", rx_data); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b exp 0", busy); end
        n_cmp++; if (overflow !== 1'b0 || frame_err !== 1'b0) begin n_err++; $display("FAIL rmid_pulses: got ovf %b ferr %b exp 0 0", overflow, frame_err); end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        f_c = ferr_cycles;
        // cs is still low: the rest of this frame must be ignored
        spi_bits(8'hFF, 8);
        n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rmid_stale_frame: got valid %b exp 0", rx_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_stale_busy: got %b exp 0", busy); end
        cs_end();
        n_cmp++; if (ferr_cycles - f_c !== 0) begin n_err++; $display("FAIL rmid_stale_ferr: got %0d exp 0", ferr_cycles - f_c); end
        cs_start();
        spi_bits(8'h5A, 8);
        cs_end();
        n_cmp++; if (int'(rx_level) !== 1) begin n_err++; $display("FAIL rmid_fresh_level: got %0d exp 1", rx_level); end
        pop_word(d);
        n_cmp++; if (d !== 8'h5A) begin n_err++; $display("FAIL rmid_fresh_word: got %h exp 5a", d); end
    endtask

    task automatic test_random();
        int n, partial, o_r, f_r, exp_ferr;
        logic [DATA_W-1:0] w, d, e;
        for (int it = 0; it < 8; it++) begin
            exp_q.delete();
            exp_drop = 0;
            o_r = ovf_rises;
            f_r = ferr_rises;
            n = $urandom_range(1, 6);
            partial = (it % 2 == 1) ? $urandom_range(1, DATA_W - 1) : 0;
            exp_ferr = (partial > 0) ? 1 : 0;
            cs_start();
            for (int i = 0; i < n; i++) begin
                w = DATA_W'($urandom);
                model_push(w);
                spi_bits(w, 8);
            end
            if (partial > 0) spi_bits(DATA_W'($urandom), partial);
            cs_end();
            n_cmp++; if (ovf_rises - o_r !== exp_drop) begin n_err++; $display("FAIL rnd%0d_ovf: got %0d exp %0d", it, ovf_rises - o_r, exp_drop); end
            n_cmp++; if (ferr_rises - f_r !== exp_ferr) begin n_err++; $display("FAIL rnd%0d_ferr: got %0d exp %0d", it, ferr_rises - f_r, exp_ferr); end
            while (exp_q.size() > 0) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                n_cmp++; if (int'(rx_level) !== exp_q.size()) begin n_err++; $display("FAIL rnd%0d_level: got %0d exp %0d", it, rx_level, exp_q.size()); end
                pop_word(d);
                e = exp_q.pop_front();
                n_cmp++; if (d !== e) begin n_err++; $display("FAIL rnd%0d_word: got %h exp %h", it, d, e); end
            end
            n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL rnd%0d_empty: got valid %b exp 0", it, rx_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_latency();
        test_multi_word();
        test_overflow();
        test_frame_err();
        test_full_pop();
        test_idle_sclk();
        test_reset_mid_word();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 Parameter DATA_W, default 8: bits per received word, MSB first.
REQ-002 Parameter FIFO_DEPTH, default 4: receive FIFO entries; must be a power of two, at least 2.
REQ-003 clk  input  1: single system clock; all state changes on its rising edge; at least 8x the SPI sclk rate.
REQ-004 rst  input  1: asynchronous, active-low reset.
REQ-005 sclk  input  1: SPI serial clock from master, asynchronous to clk.
REQ-006 cs  input  1: SPI chip select, active low, asynchronous to clk.
REQ-007 mosi  input  1: SPI data from master; master changes it on sclk rising edge.
REQ-008 rx_data  output  DATA_W: head FIFO word; valid only while rx_valid=1.
REQ-009 rx_valid  output  1: FIFO non-empty.
REQ-010 rx_ready  input  1: consumer accepts head word when rx_valid=1 and rx_ready=1.
REQ-011 rx_level  output  $clog2(FIFO_DEPTH)+1: current FIFO occupancy, 0..FIFO_DEPTH.
REQ-012 overflow  output  1: one-clk pulse when a completed word is dropped.
REQ-013 frame_err  output  1: one-clk pulse when cs rises with a partial word.
REQ-014 busy  output  1: high while the FSM is in ACTIVE.

Function
REQ-015 sclk, cs and mosi SHALL each pass through a 2-flop synchronizer; a third sclk flop and a third cs flop SHALL provide edge detection.
REQ-016 sclk falling edge = synchronized sclk 1 -> 0; cs falling/rising edge = synchronized cs 1 -> 0 / 0 -> 1.
REQ-017 FSM states: IDLE and ACTIVE only.
REQ-018 IDLE -> ACTIVE on cs falling edge; bit_cnt cleared and shift register cleared.
REQ-019 In ACTIVE, each sclk falling edge SHALL shift synchronized mosi into shift register LSB (left shift) and increment bit_cnt.
REQ-020 When the DATA_W-th bit is sampled, the assembled word SHALL be pushed into the FIFO in the same cycle; bit_cnt wraps to 0; FSM stays ACTIVE (multi-word frames supported).
REQ-021 ACTIVE -> IDLE on cs rising edge; if bit_cnt != 0, frame_err SHALL pulse for exactly one clk and the partial word SHALL be discarded.
REQ-022 cs rising edge and sclk falling edge in the same clk: the cs edge wins; the sclk edge is ignored.
REQ-023 sclk edges in IDLE SHALL be ignored.
REQ-024 Push with FIFO full and no pop in the same cycle: word dropped; FIFO unchanged; overflow pulses one clk.
REQ-025 Push and pop in the same cycle SHALL both occur, including when the FIFO is full or holds one entry; rx_level unchanged.
REQ-026 Pop with FIFO empty SHALL have no effect.
REQ-027 rx_data SHALL be driven from the head entry of the FIFO, not registered, so it is valid in the same cycle rx_valid rises.
REQ-028 FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
REQ-029 Latency: with the FIFO empty, rx_valid SHALL rise on the 4th clk rising edge after the input sclk falls for the last bit (2 sync stages, 1 edge stage, 1 write).

Reset
REQ-030 While rst=0: FSM=IDLE; bit_cnt=0; shift register=0; FIFO empty (pointers=0).
REQ-031 While rst=0: rx_valid=0, rx_level=0, overflow=0, frame_err=0, busy=0; rx_data=0.
REQ-032 While rst=0: cs synchronizer flops=1; sclk and mosi synchronizer flops=0.
REQ-033 Reset asserted mid-word SHALL discard the partial word and all FIFO contents.
REQ-034 After rst releases, a frame already in progress (cs low) SHALL be ignored until cs rises and falls again.

Verification
REQ-035 Single word: cs low, 8 bits 1,0,0,1,0,0,1,0, cs high -> rx_data=0x92, rx_valid=1, rx_level=1, no frame_err.
REQ-036 Multi-word frame: 0xA5, 0x3C, 0xFF, 0x00 in one cs-low frame, rx_ready=0 -> rx_level=4; pops return them in that order.
REQ-037 Overflow: 5 words with rx_ready=0, FIFO_DEPTH=4 -> overflow pulses once on the 5th word; FIFO holds the first 4 words.
REQ-038 Framing error: cs rises after 5 bits -> frame_err one-clk pulse, rx_level=0. Next full word 0x81 is received correctly.
REQ-039 Full plus simultaneous pop: FIFO full, rx_ready=1 as a 5th word completes -> no overflow, rx_level stays 4, oldest word popped.
REQ-040 Reset mid-word: rst low after 3 bits, then rst high -> all outputs at reset values. A fresh cs frame with 0x5A yields 0x5A.
